// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Shared types and constants for the fetch/data memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Arbiter ownership of the single memory port.
    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_INSTR = 2'd1,
        ARB_DATA  = 2'd2
    } arb_state_t;

    // Width of the optional performance counters.
    localparam int unsigned c_PERF_CNT_W = 32;

endpackage
`default_nettype wire

// File: rtl/mem_arb_perf.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_perf
// Brief    : Pair of saturating event counters for arbiter contention and
//            memory occupancy. Instantiated only when MEM_ARB_PERF_CNT_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arb_perf
    import mem_arb_pkg::*;
#(
    parameter int unsigned CNT_W = c_PERF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_conflict,
    input  logic             i_busy,
    output logic [CNT_W-1:0] o_conflict_cnt,
    output logic [CNT_W-1:0] o_busy_cnt
);

    logic [CNT_W-1:0] r_conflict_cnt;
    logic [CNT_W-1:0] r_busy_cnt;

    // Count events, holding at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
            r_busy_cnt     <= '0;
        end else begin
            if (i_conflict && (r_conflict_cnt != '1)) begin
                r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
            end
            if (i_busy && (r_busy_cnt != '1)) begin
                r_busy_cnt <= r_busy_cnt + CNT_W'(1);
            end
        end
    end

    assign o_conflict_cnt = r_conflict_cnt;
    assign o_busy_cnt     = r_busy_cnt;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Serialises instruction-fetch and load/store accesses onto one
//            single-port, variable-latency memory. Data wins ties from idle;
//            on completion the other port is granted directly, giving strict
//            alternation under contention.
//            Optional macro MEM_ARB_PERF_CNT_EN adds perf_conflict/perf_busy.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall_f,
    output logic              stall_m
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_conflict,
    output logic [31:0]       perf_busy
`endif
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_done_i;
    logic              w_done_d;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_i_valid;
    logic              r_d_valid;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and grant decode; the completing port is not re-granted in
    // its own completion cycle, so the other port always gets the next turn.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        w_done_i    = 1'b0;
        w_done_d    = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                if (d_req) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ARB_DATA;
                end else if (i_req) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ARB_INSTR;
                end
            end
            ARB_INSTR: begin
                if (mem_ready) begin
                    w_done_i = 1'b1;
                    if (d_req) begin
                        w_grant_d   = 1'b1;
                        w_state_nxt = ARB_DATA;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            ARB_DATA: begin
                if (mem_ready) begin
                    w_done_d = 1'b1;
                    if (i_req) begin
                        w_grant_i   = 1'b1;
                        w_state_nxt = ARB_INSTR;
                    end else begin
                        w_state_nxt = ARB_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    // Memory-side registers, read-data capture and completion pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_valid   <= 1'b0;
            r_d_valid   <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
        end else begin
            r_mem_req <= (w_state_nxt != ARB_IDLE);
            r_i_valid <= w_done_i;
            r_d_valid <= w_done_d;
            if (w_grant_d) begin
                r_mem_addr  <= d_addr;
                r_mem_we    <= d_we;
                r_mem_wdata <= d_wdata;
            end else if (w_grant_i) begin
                r_mem_addr <= i_addr;
                r_mem_we   <= 1'b0;
            end else if (w_state_nxt == ARB_IDLE) begin
                r_mem_we   <= 1'b0;
            end
            if (w_done_i) begin
                r_i_rdata <= mem_rdata;
            end
            // Stores complete without disturbing the last load result.
            if (w_done_d && !r_mem_we) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_valid   = r_i_valid;
    assign d_valid   = r_d_valid;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign stall_f   = i_req & ~r_i_valid;
    assign stall_m   = d_req & ~r_d_valid;

`ifdef MEM_ARB_PERF_CNT_EN
    logic w_conflict;

    // Both ports waiting with neither being served this cycle.
    assign w_conflict = i_req & d_req & ~r_i_valid & ~r_d_valid;

    mem_arb_perf #(
        .CNT_W (32)
    ) u_perf (
        .clk            (clk),
        .rst            (reset),
        .i_conflict     (w_conflict),
        .i_busy         (r_mem_req),
        .o_conflict_cnt (perf_conflict),
        .o_busy_cnt     (perf_busy)
    );
`else
    // Counters absent; arbitration behaviour is unchanged.
`endif

endmodule
`default_nettype wire
